// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider for the DIV/DIVU instructions.
// The result is {remainder, quotient}. Execute holds start_i high until
// ready_o is seen, then drops it. annul_i abandons a division in flight.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        negQuot_q, negQuot_d;
    logic        negRem_q, negRem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] dividendMag;
    logic [31:0] divisorMag;
    logic [32:0] diff;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        abort;

    // Magnitudes are only taken in signed mode. Negating 0x80000000 yields
    // 0x80000000, which is the correct unsigned magnitude.
    assign dividendMag = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    assign divisorMag  = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;

    // Trial subtraction of the divisor from the partial remainder plus the
    // next dividend bit. The partial remainder is always below the divisor,
    // so bit 32 is a reliable borrow flag.
    assign diff = work_q[64:32] - {1'b0, divisor_q};

    // Sign fix-up of the final quotient and remainder.
    assign quotient  = negQuot_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
    assign remainder = negRem_q  ? (32'd0 - work_q[64:33]) : work_q[64:33];

    // A flush kills anything; execute dropping start mid-operation does too.
    assign abort = annul_i || (!start_i && (state_q == ON || state_q == BYZERO));

    // State, iteration datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic: operand capture in FREE, one restoring step per
    // cycle in ON, result delivery into END and the handshake back to FREE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        if (abort) begin
            state_d  = FREE;
            cnt_d    = 6'd0;
            result_d = 64'd0;
            ready_d  = 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (start_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_d = BYZERO;
                        end else begin
                            state_d   = ON;
                            cnt_d     = 6'd0;
                            work_d    = {32'd0, dividendMag, 1'b0};
                            divisor_d = divisorMag;
                            negQuot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            negRem_d  = signed_div_i && opdata1_i[31];
                        end
                    end
                end
                BYZERO: begin
                    state_d  = END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
                ON: begin
                    if (cnt_q == 6'd32) begin
                        state_d  = END;
                        result_d = {remainder, quotient};
                        ready_d  = 1'b1;
                    end else begin
                        if (diff[32]) begin
                            work_d = {work_q[63:0], 1'b0};
                        end else begin
                            work_d = {diff[31:0], work_q[31:0], 1'b1};
                        end
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_d  = FREE;
                        cnt_d    = 6'd0;
                        result_d = 64'd0;
                        ready_d  = 1'b0;
                    end
                end
                default: begin
                    state_d  = FREE;
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the restoring divider: directed corner cases,
// flush and reset scenarios, and randomized operands against an
// arithmetic reference model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Latencies counted in falling edges from the one where start is driven.
    localparam int LAT_DIV  = 34;
    localparam int LAT_ZERO = 2;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero, done in
    // 64-bit so the most-negative / -1 case does not overflow.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Waits for ready_o, scrambling the operand inputs meanwhile since the
    // divider must have captured them already.
    task automatic waitReady(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ready_o) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
        end while (!ready_o && lat < 80);
    endtask

    // One complete handshake: start, wait, check, hold one cycle, release.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input logic [63:0] expected, input string tag);
        int lat;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        waitReady(lat);
        checkOutput({tag, ":latency"}, 64'(lat), 64'((b == 32'd0) ? LAT_ZERO : LAT_DIV));
        checkOutput({tag, ":result"}, result_o, expected);
        @(negedge clk);
        checkOutput({tag, ":holdReady"}, {63'd0, ready_o}, 64'd1);
        checkOutput({tag, ":holdResult"}, result_o, expected);
        start_i = 1'b0;
        @(negedge clk);
        checkOutput({tag, ":dropReady"}, {63'd0, ready_o}, 64'd0);
        checkOutput({tag, ":dropResult"}, result_o, 64'd0);
    endtask

    // Directed sequence followed by randomized divisions.
    initial begin
        int  lat;
        bit  sawReady;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #3;
        checkOutput("reset:ready", {63'd0, ready_o}, 64'd0);
        checkOutput("reset:result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "u100div7");
        applyStimulus(32'hFFFFFFF9, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "sNeg7div2");
        applyStimulus(32'h00000007, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, "s7divNeg2");
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "sMinDivNeg1");
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, "uMinDivMax");
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000_FFFFFFFF, "uMaxDiv1");
        applyStimulus(32'd5, 32'd0, 1'b0, 64'd0, "u5div0");

        // Flush after ten iterations: nothing must come out.
        @(negedge clk);
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        checkOutput("annul:ready", {63'd0, ready_o}, 64'd0);
        checkOutput("annul:result", result_o, 64'd0);
        sawReady = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) sawReady = 1'b1;
        end
        checkOutput("annul:neverReady", {63'd0, sawReady}, 64'd0);
        applyStimulus(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, "afterAnnul9div3");

        // Flush on the same edge as start: the start only takes effect one
        // edge later, which shows up as an unchanged latency from there.
        @(negedge clk);
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd5;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        waitReady(lat);
        checkOutput("annulStart:latency", 64'(lat), 64'(LAT_DIV));
        checkOutput("annulStart:result", result_o, 64'h00000000_0000000A);
        start_i = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of an iteration run.
        @(negedge clk);
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstOn:ready", {63'd0, ready_o}, 64'd0);
        checkOutput("rstOn:result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, "afterRst1000div3");

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        opdata1_i    = 32'd81;
        opdata2_i    = 32'd9;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        waitReady(lat);
        checkOutput("rstEnd:result", result_o, 64'h00000000_00000009);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstEnd:ready", {63'd0, ready_o}, 64'd0);
        checkOutput("rstEnd:clearedResult", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'hFFFFFF9C, 32'd7, 1'b1, refDiv(32'hFFFFFF9C, 32'd7, 1'b1), "afterRstNeg100div7");

        // Randomized operands with occasional zero and small divisors.
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            if (i % 5 == 0)      b = 32'd0;
            else if (i % 3 == 0) b = 32'($urandom_range(1, 15));
            else                 b = $urandom >> $urandom_range(0, 24);
            if (b == 32'd0 && i % 5 != 0) b = 32'd1;
            s = 1'($urandom_range(0, 1));
            applyStimulus(a, b, s, refDiv(a, b, s), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit radix-2 restoring divider serving the execute stage's DIV/DIVU instructions. Execute drives operands, signedness and start, and holds the pipeline stalled until this block raises ready; the 64-bit result is {remainder, quotient}, which execute writes to HI/LO. A flush input abandons an in-flight division when the instruction is killed by an exception.

## Interface

Parameters:
- None. Widths are fixed by the global bus defines: RegBus is 32 bits and DoubleRegBus is 64 bits.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous and active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by execute until ready_o is seen
- annul_i  in  1  flush; abort any operation
- result_o  out  64  [63:32] remainder, [31:0] quotient; registered
- ready_o  out  1  result valid; registered

## Operation

- State machine FREE, BYZERO, ON, END. Reset (asynchronous): state FREE, counter 0, result_o 0, ready_o 0.
- FREE, start_i=1, annul_i=0:
  - Divisor 0: go to BYZERO.
  - Otherwise go to ON. Latch the operands, the sign flags and the signed mode.
  - Work dividend = {32'b0, |opdata1_i|, 1'b0}, a 65-bit register. Divisor = |opdata2_i|. Counter = 0.
  - Magnitudes are taken only when signed_div_i=1; else the raw values are used.
- BYZERO: result register = 0. Next state END.
- ON, one iteration per cycle while counter < 32:
  - diff = work[64:32] − {1'b0, divisor}, computed 33 bits wide.
  - diff negative: work = {work[63:0], 1'b0}.
  - diff non-negative: work = {diff[31:0], work[31:0], 1'b1}.
  - Counter increments.
- ON, counter == 32:
  - quotient = work[31:0]; remainder = work[64:33].
  - In signed mode, negate the quotient if the dividend and divisor signs differ.
  - In signed mode, negate the remainder if the dividend is negative.
  - result_o = {remainder, quotient}; ready_o = 1; next state END.
- END:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0: next state FREE, ready_o = 0, result_o = 0.
- Abort: annul_i=1 in any state, or start_i=0 in ON or BYZERO.
  - Next state FREE, ready_o = 0, result_o = 0, counter = 0.
  - annul_i has priority over start_i.
- Arithmetic rules:
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000 and remainder 0. No trap.
  - The magnitude of 0x80000000 is taken as unsigned 0x80000000.
- Operands are sampled only in FREE. Changes on opdata*_i during ON are ignored.

## Timing

- Let edge T be the first edge at which FREE sees start_i=1.
  - Nonzero divisor: iterations occur on edges T+1..T+32. Result and ready_o are registered on edge T+33.
  - Zero divisor: BYZERO on edge T+1; ready_o = 1 with result 0 after edge T+1.
- ready_o stays high exactly while in END. It falls on the edge after start_i is seen low.
- Execute stalls while ready_o = 0. In the cycle where ready_o = 1 it captures result_o and drops start_i, and the block returns to FREE on the next edge.
- Back-to-back divides: a new start_i is accepted in FREE on the edge after leaving END. Minimum spacing is 35 cycles.
- A reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- An annul asserted on the same edge as start_i in FREE suppresses the start.

## Test plan

- Unsigned, 100 / 7 held with start_i: ready_o rises 33 cycles after start is sampled; result_o = 0x00000002_0000000E. Drop start: next cycle ready_o = 0 and result_o = 0.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD. Signed 7 / −2: result_o = 0x00000001_FFFFFFFD.
- Signed boundary cases:
  - 0x80000000 / 0xFFFFFFFF gives 0x00000000_80000000.
  - The same operands unsigned give 0x80000000_00000000.
  - 0xFFFFFFFF / 1 unsigned gives 0x00000000_FFFFFFFF.
- Divide by zero, 5 / 0: ready_o = 1 one cycle after the start edge; result_o = 0.
- Pulse annul_i at iteration 10: state returns to FREE and ready_o never rises. A fresh 9 / 3 issued afterwards returns 0x00000000_00000003 on schedule.
- Assert rst asynchronously mid-ON: ready_o and result_o are 0 immediately. After release, a new division completes correctly.
